mem_1rw_ctrl: RTL and testbench

Front-end controller that sits directly upstream of the single-port 1RW memory (`mem_1rw`, 16 x 4-bit by default). It accepts independent write and read request streams, arbitrates them round-robin onto the one memory port, and captures read data on the single cycle the memory makes it valid. Captured data goes into a 2-entry response FIFO with a valid/ready output. The memory's data output is only meaningful in the cycle right after a read issue, so this block owns that capture window.

---
 rtl/mem_1rw_ctrl_if.sv | 34 +++
 rtl/mem_1rw_ctrl.sv | 72 +++++++
 tb/tb_mem_1rw_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_1rw_ctrl_if.sv
// Request, response and memory-port signals of mem_1rw_ctrl.
// slave is the controller's view; master is the view of the surrounding logic.
interface mem_1rw_ctrl_if #(
   parameter int width_p      = 4,
   parameter int addr_width_p = 4
);
   logic                    wr_v_i;
   logic [addr_width_p-1:0] wr_addr_i;
   logic [width_p-1:0]      wr_data_i;
   logic                    wr_ready_o;
   logic                    rd_v_i;
   logic [addr_width_p-1:0] rd_addr_i;
   logic                    rd_ready_o;
   logic [width_p-1:0]      rd_data_o;
   logic                    rd_v_o;
   logic                    rd_ready_i;
   logic                    mem_v_o;
   logic                    mem_w_o;
   logic [addr_width_p-1:0] mem_addr_o;
   logic [width_p-1:0]      mem_data_o;
   logic [width_p-1:0]      mem_data_i;

   modport slave (
      input  wr_v_i, wr_addr_i, wr_data_i, rd_v_i, rd_addr_i, rd_ready_i, mem_data_i,
      output wr_ready_o, rd_ready_o, rd_data_o, rd_v_o,
             mem_v_o, mem_w_o, mem_addr_o, mem_data_o
   );

   modport master (
      output wr_v_i, wr_addr_i, wr_data_i, rd_v_i, rd_addr_i, rd_ready_i, mem_data_i,
      input  wr_ready_o, rd_ready_o, rd_data_o, rd_v_o,
             mem_v_o, mem_w_o, mem_addr_o, mem_data_o
   );
endinterface

// File: rtl/mem_1rw_ctrl.sv
// Round-robin write/read front end for a single-port 1RW memory, capturing
// read data in its one valid cycle into a 2-entry response FIFO.
module mem_1rw_ctrl #(
   parameter int width_p      = 4,
   parameter int els_p        = 16,
   parameter int addr_width_p = $clog2(els_p)
) (
   input logic            clk_i,
   input logic            reset_i,
   mem_1rw_ctrl_if.slave  bus
);

   logic [1:0]         r_count;
   logic               r_wptr;
   logic               r_rptr;
   logic               r_inflight;
   logic               r_last_w;
   logic [width_p-1:0] r_fifo [2];

   logic       w_pop;
   logic [2:0] w_reserved;
   logic       w_rd_elig;
   logic       w_grant_w;
   logic       w_grant_r;

   // A read may issue only if its response is guaranteed a FIFO slot,
   // counting the in-flight capture and crediting this cycle's pop.
   always_comb begin
      w_pop      = (r_count != 2'd0) & bus.rd_ready_i & ~reset_i;
      w_reserved = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
      w_rd_elig  = bus.rd_v_i & (w_reserved < 3'd2) & ~reset_i;
      w_grant_w  = bus.wr_v_i & ~reset_i & (~w_rd_elig | ~r_last_w);
      w_grant_r  = w_rd_elig & (~bus.wr_v_i | r_last_w);
   end

   assign bus.wr_ready_o = w_grant_w;
   assign bus.rd_ready_o = w_grant_r;
   assign bus.mem_v_o    = w_grant_w | w_grant_r;
   assign bus.mem_w_o    = w_grant_w;
   assign bus.mem_addr_o = w_grant_w ? bus.wr_addr_i : bus.rd_addr_i;
   assign bus.mem_data_o = bus.wr_data_i;
   assign bus.rd_v_o     = (r_count != 2'd0) & ~reset_i;
   assign bus.rd_data_o  = r_fifo[r_rptr];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_count    <= '0;
         r_wptr     <= 1'b0;
         r_rptr     <= 1'b0;
         r_inflight <= 1'b0;
         r_last_w   <= 1'b1;
      end else begin
         r_inflight <= w_grant_r;
         if (w_grant_w)
            r_last_w <= 1'b1;
         else if (w_grant_r)
            r_last_w <= 1'b0;
         if (r_inflight)
            r_wptr <= ~r_wptr;
         if (w_pop)
            r_rptr <= ~r_rptr;
         r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
      end
   end

   // Payload storage needs no reset; occupancy alone defines validity.
   always_ff @(posedge clk_i) begin
      if (r_inflight)
         r_fifo[r_wptr] <= bus.mem_data_i;
   end

endmodule

// File: tb/tb_mem_1rw_ctrl.sv
// Bench for mem_1rw_ctrl: behavioural 1RW memory plus a transaction-level
// reference of grants and the ordered response stream.
module tb_mem_1rw_ctrl;

   logic clk;
   logic reset_i;
   int   checks;
   int   errors;

   mem_1rw_ctrl_if #(.width_p(4), .addr_width_p(4)) bus ();

   mem_1rw_ctrl #(.width_p(4), .els_p(16), .addr_width_p(4)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .bus     (bus)
   );

   // 1RW memory: read data valid only in the cycle after a read issue.
   logic [3:0] mem [16];
   logic [3:0] mem_q;
   always @(posedge clk) begin
      if (bus.mem_v_o && bus.mem_w_o) begin
         mem[bus.mem_addr_o] <= bus.mem_data_o;
         mem_q <= 'x;
      end else if (bus.mem_v_o)
         mem_q <= mem[bus.mem_addr_o];
      else
         mem_q <= 'x;
   end
   assign bus.mem_data_i = mem_q;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: outstanding responses in grant order, each visible from
   // two cycles after its grant until consumed.
   typedef struct {
      logic [3:0]  d;
      bit          k;
      int unsigned rdy;
   } resp_t;

   resp_t       q[$];
   logic [3:0]  ref_mem [16];
   bit          ref_known [16];
   bit          m_last_w;
   int unsigned cyc;
   string       grant_log;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic cycle(input bit wv, input logic [3:0] wa, input logic [3:0] wd,
                        input bit rv, input logic [3:0] ra, input bit rr, input bit rst);
      bit vis, pop, elig, gw, gr;
      resp_t e;
      reset_i       = rst;
      bus.wr_v_i    = wv;
      bus.wr_addr_i = wa;
      bus.wr_data_i = wd;
      bus.rd_v_i    = rv;
      bus.rd_addr_i = ra;
      bus.rd_ready_i = rr;
      @(negedge clk);
      if (rst) begin
         chk("rst_wr_ready", {7'd0, bus.wr_ready_o}, 8'd0);
         chk("rst_rd_ready", {7'd0, bus.rd_ready_o}, 8'd0);
         chk("rst_mem_v",    {7'd0, bus.mem_v_o},    8'd0);
         chk("rst_mem_w",    {7'd0, bus.mem_w_o},    8'd0);
         chk("rst_rd_v",     {7'd0, bus.rd_v_o},     8'd0);
         q.delete();
         m_last_w = 1'b1;
      end else begin
         vis  = (q.size() > 0) && (q[0].rdy <= cyc);
         pop  = vis && rr;
         elig = rv && ((int'(q.size()) - int'(pop)) < 2);
         gw   = wv && (!elig || !m_last_w);
         gr   = elig && (!wv || m_last_w);
         chk("wr_ready", {7'd0, bus.wr_ready_o}, {7'd0, gw});
         chk("rd_ready", {7'd0, bus.rd_ready_o}, {7'd0, gr});
         chk("mem_v",    {7'd0, bus.mem_v_o},    {7'd0, gw | gr});
         chk("rd_v",     {7'd0, bus.rd_v_o},     {7'd0, vis});
         if (vis && q[0].k)
            chk("rd_data", {4'd0, bus.rd_data_o}, {4'd0, q[0].d});
         if (gw || gr) begin
            chk("mem_w",    {7'd0, bus.mem_w_o},    {7'd0, gw});
            chk("mem_addr", {4'd0, bus.mem_addr_o}, {4'd0, gw ? wa : ra});
         end
         if (gw)
            chk("mem_data", {4'd0, bus.mem_data_o}, {4'd0, wd});
         if (bus.rd_ready_o)
            chk("no_overflow", {7'd0, ((int'(q.size()) - int'(pop)) < 2)}, 8'd1);
         if (gw) grant_log = {grant_log, "W"};
         else if (gr) grant_log = {grant_log, "R"};
         else grant_log = {grant_log, "-"};
         if (pop) void'(q.pop_front());
         if (gw) begin
            ref_mem[wa]   = wd;
            ref_known[wa] = 1'b1;
            m_last_w      = 1'b1;
         end
         if (gr) begin
            e.d = ref_mem[ra];
            e.k = ref_known[ra];
            e.rdy = cyc + 2;
            q.push_back(e);
            m_last_w = 1'b0;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 4'd0, 4'd0, 0, 4'd0, 1, 0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc = 0;
      m_last_w = 1'b1;
      for (int i = 0; i < 16; i++) ref_known[i] = 1'b0;

      // reset with both requests held, then the first tie goes to the read
      cycle(1, 4'd1, 4'd2, 1, 4'd1, 1, 1);
      cycle(1, 4'd1, 4'd2, 1, 4'd1, 1, 1);
      grant_log = "";
      cycle(1, 4'd1, 4'd2, 1, 4'd1, 1, 0);
      chk("first_grant_read", {7'd0, grant_log.substr(0, 0) == "R"}, 8'd1);
      idle(4);

      // write then read same address
      cycle(1, 4'd3, 4'hA, 0, 4'd0, 1, 0);
      cycle(0, 4'd0, 4'd0, 1, 4'd3, 1, 0);
      cycle(0, 4'd0, 4'd0, 0, 4'd0, 1, 0);
      chk("wr_rd_lat", {3'd0, bus.rd_v_o, bus.rd_data_o}, {4'h1, 4'hA});
      idle(3);

      // streaming reads
      for (int i = 0; i < 16; i++) cycle(1, 4'(i), 4'(i), 0, 4'd0, 1, 0);
      for (int i = 0; i < 16; i++) cycle(0, 4'd0, 4'd0, 1, 4'(i), 1, 0);
      idle(4);

      // backpressure then drain
      for (int i = 0; i < 6; i++) cycle(0, 4'd0, 4'd0, 1, 4'(i + 4), 0, 0);
      chk("bp_held_head", {3'd0, bus.rd_v_o, bus.rd_data_o}, {4'h1, 4'h4});
      idle(4);

      // contention after reset
      cycle(0, 4'd0, 4'd0, 0, 4'd0, 1, 1);
      cycle(0, 4'd0, 4'd0, 0, 4'd0, 1, 1);
      grant_log = "";
      for (int i = 0; i < 6; i++) cycle(1, 4'd5, 4'(i + 9), 1, 4'd5, 1, 0);
      chk("contention_order", {7'd0, grant_log == "RWRWRW"}, 8'd1);
      idle(4);

      // reset one cycle after a read grant drops that read
      cycle(1, 4'd7, 4'h3, 0, 4'd0, 1, 0);
      idle(2);
      cycle(0, 4'd0, 4'd0, 1, 4'd7, 1, 0);
      cycle(0, 4'd0, 4'd0, 0, 4'd0, 1, 1);
      idle(3);
      cycle(0, 4'd0, 4'd0, 1, 4'd7, 1, 0);
      idle(3);

      // randomized traffic with occasional reset
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0));
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
